// File: rtl/bcd_digit_sequencer_pkg.sv
// Shared types and helpers for the BCD digit sequencer: FSM state encoding,
// nibble width and constant-evaluable sizing functions.
package bcd_digit_sequencer_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2,
    GAP     = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((longint'(1) << r) < longint'(v)) r = r + 1;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd_digit_sequencer_add3.sv
// Double-dabble correction for one BCD nibble: values of 5 or more get +3
// so the following left shift carries correctly into the next decade.
module bcd_add3
  import bcd_digit_sequencer_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic [NIBBLE_W-1:0] nibble_o
);

  always_comb begin
    nibble_o = nibble_i;
    if (nibble_i >= 4'd5) nibble_o = nibble_i + 4'd3;
  end

endmodule

// File: rtl/bcd_digit_sequencer.sv
// Serial binary-to-BCD converter that then presents the decimal digits one at
// a time (MSD first, leading zeros suppressed) with a hold and a blank gap.
module bcd_digit_sequencer
  import bcd_digit_sequencer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NDIGITS    = 3,
  parameter int HOLD_COUNT = 10_000_000,
  parameter int GAP_COUNT  = 2_000_000,
  localparam int IDX_W     = clog2(NDIGITS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             busy_o,
  output logic [3:0]       digit_o,
  output logic             digit_valid_o,
  output logic [IDX_W-1:0] digit_index_o,
  output logic             done_o,
  output state_e           state_o
);

  localparam int BCD_W = NDIGITS * NIBBLE_W;
  localparam int CNT_W = clog2(max2(HOLD_COUNT, GAP_COUNT) + 1);
  localparam int BIT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_COUNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_COUNT > 0) ? GAP_COUNT - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   pos_q, pos_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic [WIDTH-1:0]   bin_shift;
  logic [IDX_W-1:0]   first_pos;
  logic [3:0]         cur_nib;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble_i (bcd_q[g*NIBBLE_W +: NIBBLE_W]),
      .nibble_o (bcd_adj[g*NIBBLE_W +: NIBBLE_W])
    );
  end

  assign {bcd_shift, bin_shift} = {bcd_adj, bin_q} << 1;

  // Most significant nonzero nibble of the final result; 0 maps to nibble 0.
  always_comb begin
    first_pos = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd_shift[i*NIBBLE_W +: NIBBLE_W] != '0) first_pos = IDX_W'(i);
    end
  end

  always_comb begin
    cur_nib = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (pos_q == IDX_W'(i)) cur_nib = bcd_q[i*NIBBLE_W +: NIBBLE_W];
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          bin_d   = value_i;
          bcd_d   = '0;
          bit_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bin_d = bin_shift;
        bcd_d = bcd_shift;
        if (bit_q == BIT_LAST) begin
          bit_d   = '0;
          cnt_d   = '0;
          pos_d   = first_pos;
          idx_d   = '0;
          state_d = SHOW;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      SHOW: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (GAP_COUNT > 0) begin
            state_d = GAP;
          end else if (pos_q == '0) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            pos_d = pos_q - IDX_W'(1);
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (pos_q == '0) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            pos_d   = pos_q - IDX_W'(1);
            idx_d   = idx_q + IDX_W'(1);
            state_d = SHOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Outputs decode directly from registered state so reset clears them at once.
  assign busy_o        = (state_q != IDLE);
  assign digit_valid_o = (state_q == SHOW);
  assign digit_o       = digit_valid_o ? cur_nib : 4'd0;
  assign digit_index_o = idx_q;
  assign done_o        = done_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Bench for bcd_digit_sequencer with short hold/gap: expected {index,digit}
// pairs are queued at start and popped as each digit appears.
module tb_bcd_digit_sequencer;
  import bcd_digit_sequencer_pkg::*;

  localparam int WIDTH = 8;
  localparam int NDIG  = 3;
  localparam int HOLD  = 4;
  localparam int GAPC  = 2;
  localparam int IDX_W = 3;
  localparam int W     = IDX_W + 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic [3:0]       digit;
  logic             digit_valid;
  logic [IDX_W-1:0] digit_index;
  logic             done;
  state_e           state;

  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int fails = 0;

  bcd_digit_sequencer #(
    .WIDTH(WIDTH), .NDIGITS(NDIG), .HOLD_COUNT(HOLD), .GAP_COUNT(GAPC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .value_i       (value),
    .busy_o        (busy),
    .digit_o       (digit),
    .digit_valid_o (digit_valid),
    .digit_index_o (digit_index),
    .done_o        (done),
    .state_o       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_expected(input logic [WIDTH-1:0] v);
    int d[3];
    int f;
    d[0] = int'(v) / 100;
    d[1] = (int'(v) / 10) % 10;
    d[2] = int'(v) % 10;
    f = (d[0] != 0) ? 0 : ((d[1] != 0) ? 1 : 2);
    for (int i = f; i < 3; i++) exp_q.push_back({IDX_W'(i - f), 4'(d[i])});
  endtask

  // Entered at the first sample after the accepting edge.
  task automatic monitor_seq(input bit inject, input bit chain, input logic [WIDTH-1:0] chain_v);
    int busy_cyc, hold_run, gap_run, ndig;
    bit prev_valid, finished;
    logic [3:0] held;
    logic [W-1:0] exp;
    tests_run++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_rise got=%b exp=1", busy); end
    busy_cyc = 1; hold_run = 0; gap_run = 0; ndig = 0; prev_valid = 0; finished = 0; held = 0;
    for (int c = 0; c < 200 && !finished; c++) begin
      @(posedge clk); #1;
      if (done) begin
        finished = 1;
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL busy_at_done got=%b exp=0", busy); end
        tests_run++;
        if (busy_cyc != 8 + ndig * (HOLD + GAPC)) begin
          fails++; $display("FAIL busy_len got=%0d exp=%0d", busy_cyc, 8 + ndig * (HOLD + GAPC));
        end
        tests_run++;
        if (gap_run != GAPC) begin fails++; $display("FAIL last_gap got=%0d exp=%0d", gap_run, GAPC); end
        if (chain) begin
          push_expected(chain_v);
          start = 1'b1;
          value = chain_v;
        end
      end else begin
        busy_cyc++;
        tests_run++;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy_hold got=%b exp=1", busy); end
        if (digit_valid) begin
          if (!prev_valid) begin
            if (ndig > 0) begin
              tests_run++;
              if (gap_run != GAPC) begin fails++; $display("FAIL gap_len got=%0d exp=%0d", gap_run, GAPC); end
            end
            tests_run++;
            if (exp_q.size() == 0) begin
              fails++; $display("FAIL extra_digit got=%0d/%0d exp=none", digit_index, digit);
            end else begin
              exp = exp_q.pop_front();
              if ({digit_index, digit} !== exp) begin
                fails++; $display("FAIL digit got=idx%0d:%0d exp=idx%0d:%0d",
                                  digit_index, digit, exp[W-1:4], exp[3:0]);
              end
            end
            ndig++; hold_run = 1; held = digit;
          end else begin
            hold_run++;
            tests_run++;
            if (digit !== held) begin fails++; $display("FAIL digit_stable got=%0d exp=%0d", digit, held); end
          end
        end else begin
          tests_run++;
          if (digit !== 4'd0) begin fails++; $display("FAIL blank_digit got=%0d exp=0", digit); end
          if (prev_valid) begin
            tests_run++;
            if (hold_run != HOLD) begin fails++; $display("FAIL hold_len got=%0d exp=%0d", hold_run, HOLD); end
            gap_run = 1;
          end else if (ndig > 0) begin
            gap_run++;
          end
        end
        prev_valid = digit_valid;
        if (inject && ndig == 1 && digit_valid && hold_run == 2) begin
          start = 1'b1;
          value = 8'd99;
        end else if (inject) begin
          start = 1'b0;
        end
      end
    end
    tests_run++;
    if (!finished) begin fails++; $display("FAIL timeout got=no_done exp=done"); end
    tests_run++;
    if (!chain && exp_q.size() != 0) begin
      fails++; $display("FAIL missing_digits got=%0d_left exp=0", exp_q.size());
    end
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_pulse got=%b exp=0", done); end
  endtask

  task automatic run_value(input logic [WIDTH-1:0] v, input bit inject);
    push_expected(v);
    start = 1'b1;
    value = v;
    @(posedge clk); #1;
    start = 1'b0;
    value = WIDTH'($urandom_range(0, 255));
    monitor_seq(inject, 1'b0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; value = '0;
    #12;
    tests_run++;
    if ({busy, digit, digit_valid, digit_index, done} !== '0 || state !== IDLE) begin
      fails++; $display("FAIL reset_outputs got=%b%b%b%b%b/%0d exp=0/IDLE",
                        busy, digit, digit_valid, digit_index, done, state);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_values();
    logic [WIDTH-1:0] vals[6];
    vals = '{8'd173, 8'd0, 8'd5, 8'd40, 8'd200, 8'd255};
    foreach (vals[i]) run_value(vals[i], 1'b0);
    for (int i = 0; i < 3; i++) run_value(WIDTH'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic test_ignore_start();
    run_value(8'd173, 1'b1);
  endtask

  task automatic test_back_to_back();
    push_expected(8'd40);
    start = 1'b1; value = 8'd40;
    @(posedge clk); #1;
    start = 1'b0;
    monitor_seq(1'b0, 1'b1, 8'd255);
    monitor_seq(1'b0, 1'b0, '0);
  endtask

  task automatic test_async_reset();
    bit seen;
    seen = 0;
    start = 1'b1; value = 8'd173;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk); #1;
      if (digit_valid && digit == 4'd7) seen = 1;
    end
    tests_run++;
    if (!seen) begin fails++; $display("FAIL reach_digit7 got=not_seen exp=seen"); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, digit, digit_valid, done} !== '0) begin
      fails++; $display("FAIL async_reset got=%b%b%b%b exp=0", busy, digit, digit_valid, done);
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (state !== IDLE || busy !== 1'b0) begin
      fails++; $display("FAIL post_reset got=%0d/%b exp=IDLE/0", state, busy);
    end
    run_value(8'd9, 1'b0);
  endtask

  initial begin
    test_reset();
    test_values();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
